// File: rtl/div_scheduler.sv
// Round-robin front end that shares one sequential divider among NREQ requesters,
// resolving divide-by-zero locally and aborting a divider that never reports done.
module div_scheduler #(
    parameter int WIDTH   = 24,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2*WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divisor,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [7:0]            rsp_quo,
    output logic [WIDTH-1:0]      rsp_rem,
    output logic                  rsp_dz,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic                  div_done,
    input  logic [7:0]            div_quo,
    input  logic [WIDTH-1:0]      div_rem
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [CW-1:0]     wd_q, wd_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_quo_q, rsp_quo_d;
    logic [WIDTH-1:0]  rsp_rem_q, rsp_rem_d;
    logic              rsp_dz_q, rsp_dz_d;
    logic              rsp_err_q, rsp_err_d;
    logic              div_start_q, div_start_d;
    logic [WIDTH-1:0]  div_dividend_q, div_dividend_d;
    logic [WIDTH-1:0]  div_divisor_q, div_divisor_d;

    logic [PW-1:0]     sel;
    logic              found;
    logic [PW:0]       idx;
    logic [WIDTH-1:0]  sel_a, sel_b;

    // Scan from ptr upward, wrapping at NREQ-1; first set request wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                sel   = idx[PW-1:0];
            end
        end
    end

    assign sel_a = req_dividend[int'(sel)*WIDTH +: WIDTH];
    assign sel_b = req_divisor[int'(sel)*WIDTH +: WIDTH];

    always_comb begin
        ack = '0;
        if (nrst && state_q == IDLE && found) begin
            ack[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        gnt_d          = gnt_q;
        wd_d           = wd_q;
        rsp_valid_d    = '0;
        rsp_quo_d      = rsp_quo_q;
        rsp_rem_d      = rsp_rem_q;
        rsp_dz_d       = rsp_dz_q;
        rsp_err_d      = rsp_err_q;
        div_start_d    = 1'b0;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d = sel;
                    ptr_d = (sel == PW'(NREQ-1)) ? '0 : sel + PW'(1);
                    if (sel_b == '0) begin
                        rsp_quo_d       = 8'hFF;
                        rsp_rem_d       = sel_a;
                        rsp_dz_d        = 1'b1;
                        rsp_err_d       = 1'b0;
                        rsp_valid_d[sel] = 1'b1;
                        state_d         = RESP;
                    end else begin
                        div_dividend_d = sel_a;
                        div_divisor_d  = sel_b;
                        div_start_d    = 1'b1;
                        state_d        = START;
                    end
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done takes priority over a timeout landing in the same cycle
                if (div_done) begin
                    rsp_quo_d          = div_quo;
                    rsp_rem_d          = div_rem;
                    rsp_dz_d           = 1'b0;
                    rsp_err_d          = 1'b0;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = RESP;
                end else if (wd_q == CW'(TIMEOUT-1)) begin
                    rsp_quo_d          = '0;
                    rsp_rem_d          = '0;
                    rsp_dz_d           = 1'b0;
                    rsp_err_d          = 1'b1;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = RESP;
                end else begin
                    wd_d = wd_q + CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            gnt_q          <= '0;
            wd_q           <= '0;
            rsp_valid_q    <= '0;
            rsp_quo_q      <= '0;
            rsp_rem_q      <= '0;
            rsp_dz_q       <= 1'b0;
            rsp_err_q      <= 1'b0;
            div_start_q    <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            gnt_q          <= gnt_d;
            wd_q           <= wd_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_quo_q      <= rsp_quo_d;
            rsp_rem_q      <= rsp_rem_d;
            rsp_dz_q       <= rsp_dz_d;
            rsp_err_q      <= rsp_err_d;
            div_start_q    <= div_start_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_quo      = rsp_quo_q;
    assign rsp_rem      = rsp_rem_q;
    assign rsp_dz       = rsp_dz_q;
    assign rsp_err      = rsp_err_q;
    assign div_start    = div_start_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: transaction-level model of arbitration and result timing,
// a behavioural divider with controllable latency, directed cases and a random phase.
module tb_div_scheduler;
    localparam int W    = 24;
    localparam int NREQ = 4;
    localparam int TO   = 48;

    logic                 clk;
    logic                 nrst;
    logic [NREQ-1:0]      req;
    logic [NREQ*W-1:0]    req_dividend;
    logic [NREQ*W-1:0]    req_divisor;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      rsp_valid;
    logic [7:0]           rsp_quo;
    logic [W-1:0]         rsp_rem;
    logic                 rsp_dz;
    logic                 rsp_err;
    logic                 busy;
    logic                 div_start;
    logic [W-1:0]         div_dividend;
    logic [W-1:0]         div_divisor;
    logic                 div_done;
    logic [7:0]           div_quo;
    logic [W-1:0]         div_rem;

    div_scheduler #(.WIDTH(W), .NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst), .req(req),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_quo(rsp_quo), .rsp_rem(rsp_rem),
        .rsp_dz(rsp_dz), .rsp_err(rsp_err), .busy(busy),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quo(div_quo), .div_rem(div_rem)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat_mode = 0;      // 0: done after W cycles, 1: random latency, 2: never
    int done_cyc = -100;
    int spur_cyc = -100;
    logic [W-1:0] dv_a = '0, dv_b = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Divider model: computes from the operands presented with div_start.
    always @(negedge clk) begin
        if (div_start) begin
            dv_a = div_dividend;
            dv_b = div_divisor;
        end
    end

    always @(posedge clk) begin
        #1;
        if (cyc == done_cyc || cyc == spur_cyc) begin
            div_done = 1'b1;
            div_quo  = (dv_b != 0) ? 8'(dv_a / dv_b) : 8'h00;
            div_rem  = (dv_b != 0) ? dv_a % dv_b : '0;
        end else begin
            div_done = 1'b0;
            div_quo  = 8'($urandom);
            div_rem  = W'($urandom);
        end
    end

    // Reference model: one transaction at a time, timing from the ack cycle.
    int m_act = 0, m_g = 0, m_ptr = 0, m_ack = 0, m_start = -1, m_rsp = -1;
    logic [W-1:0] m_a, m_b;
    logic [7:0]   e_quo, l_quo;
    logic [W-1:0] e_rem, l_rem, l_da, l_db;
    logic         e_dz, e_err, l_dz, l_err;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_ack, exp_rv;
        int g, lat;
        if (!nrst) begin
            check("rst_ack", ack, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_quo", rsp_quo, 0);
            check("rst_rem", rsp_rem, 0);
            check("rst_dz", rsp_dz, 0);
            check("rst_err", rsp_err, 0);
            check("rst_busy", busy, 0);
            check("rst_start", div_start, 0);
            check("rst_dividend", div_dividend, 0);
            check("rst_divisor", div_divisor, 0);
            m_act = 0; m_ptr = 0; m_start = -1; m_rsp = -1;
            l_quo = '0; l_rem = '0; l_dz = 1'b0; l_err = 1'b0; l_da = '0; l_db = '0;
            done_cyc = -100;
        end else begin
            exp_ack = '0;
            if ((m_act == 0 || cyc > m_rsp) && req != '0) begin
                g = -1;
                for (int i = 0; i < NREQ; i++)
                    if (g < 0 && req[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
                exp_ack[g] = 1'b1;
                m_a = req_dividend[g*W +: W];
                m_b = req_divisor[g*W +: W];
                m_act = 1; m_g = g; m_ack = cyc; m_ptr = (g + 1) % NREQ;
                if (m_b == 0) begin
                    m_start = -1; m_rsp = cyc + 1;
                    e_quo = 8'hFF; e_rem = m_a; e_dz = 1'b1; e_err = 1'b0;
                end else begin
                    if (lat_mode == 0) lat = W;
                    else if (lat_mode == 2) lat = 1000;
                    else lat = ($urandom_range(0, 2) == 0) ? W : int'($urandom_range(0, TO + 2));
                    m_start = cyc + 1;
                    done_cyc = cyc + 1 + lat;
                    if (lat >= 1 && lat <= TO) begin
                        m_rsp = cyc + 2 + lat;
                        e_quo = 8'(m_a / m_b); e_rem = m_a % m_b; e_dz = 1'b0; e_err = 1'b0;
                    end else begin
                        m_rsp = cyc + 2 + TO;
                        e_quo = '0; e_rem = '0; e_dz = 1'b0; e_err = 1'b1;
                    end
                end
            end
            if (m_act != 0 && cyc == m_start) begin
                l_da = m_a; l_db = m_b;
            end
            exp_rv = '0;
            if (m_act != 0 && cyc == m_rsp) begin
                exp_rv[m_g] = 1'b1;
                l_quo = e_quo; l_rem = e_rem; l_dz = e_dz; l_err = e_err;
            end
            check("ack", ack, exp_ack);
            check("busy", busy, (m_act != 0 && cyc > m_ack && cyc <= m_rsp) ? 1 : 0);
            check("div_start", div_start, (m_act != 0 && cyc == m_start) ? 1 : 0);
            check("div_dividend", div_dividend, l_da);
            check("div_divisor", div_divisor, l_db);
            check("rsp_valid", rsp_valid, exp_rv);
            check("rsp_quo", rsp_quo, l_quo);
            check("rsp_rem", rsp_rem, l_rem);
            check("rsp_dz", rsp_dz, l_dz);
            check("rsp_err", rsp_err, l_err);
        end
    end

    task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
        req_dividend[k*W +: W] = a;
        req_divisor[k*W +: W]  = b;
    endtask

    function automatic logic [W-1:0] rnd_divisor();
        case ($urandom_range(0, 7))
            0:       return '0;
            1, 2:    return W'($urandom_range(1, 300));
            default: return W'($urandom) | W'(1);
        endcase
    endfunction

    task automatic next_ack(output logic [NREQ-1:0] a, output int c);
        int n = 0;
        a = '0; c = -1;
        while (c < 0 && n < 300) begin
            @(negedge clk);
            if (ack != '0) begin a = ack; c = cyc; end
            n++;
        end
        if (c < 0) check("ack_wait_expired", 0, 1);
    endtask

    task automatic wait_rsp(input int k, output int c, output logic [7:0] q,
                            output logic [W-1:0] r, output logic dz, output logic er);
        int n = 0;
        c = -1; q = '0; r = '0; dz = 1'b0; er = 1'b0;
        while (c < 0 && n < 300) begin
            @(negedge clk);
            if (rsp_valid[k]) begin c = cyc; q = rsp_quo; r = rsp_rem; dz = rsp_dz; er = rsp_err; end
            n++;
        end
        if (c < 0) check("rsp_wait_expired", 0, 1);
    endtask

    initial begin
        logic [NREQ-1:0] a, acked;
        int ca, cr, cprev;
        logic [7:0] q;
        logic [W-1:0] r;
        logic dz, er;
        nrst = 1'b0;
        req = '0;
        req_dividend = '0;
        req_divisor = '0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;

        // Fairness: all four held high from reset.
        for (int k = 0; k < NREQ; k++) set_ops(k, W'($urandom), W'($urandom_range(1, 5000)));
        req = '1;
        cprev = 0;
        for (int i = 0; i < 8; i++) begin
            next_ack(a, ca);
            check("fair_order", a, 4'b0001 << (i % NREQ));
            if (i > 0) check("fair_spacing", ca - cprev, W + 3);
            cprev = ca;
        end
        @(posedge clk); #1 req = '0;
        wait_rsp(3, cr, q, r, dz, er);

        // Pointer wrap: after grant to 3, {0,1} together -> 0 then 1.
        set_ops(0, W'(100), W'(9));
        set_ops(1, W'(200), W'(11));
        @(posedge clk); #1 req = 4'b0011;
        next_ack(a, ca);
        check("wrap_first", a, 4'b0001);
        @(posedge clk); #1 req[0] = 1'b0;
        next_ack(a, ca);
        check("wrap_second", a, 4'b0010);
        @(posedge clk); #1 req[1] = 1'b0;
        wait_rsp(1, cr, q, r, dz, er);
        check("wrap_quo", q, 18);
        check("wrap_rem", r, 2);

        // Single request 1000/7 on requester 2.
        set_ops(2, W'(1000), W'(7));
        @(posedge clk); #1 req[2] = 1'b1;
        next_ack(a, ca);
        check("single_ack", a, 4'b0100);
        @(posedge clk); #1 req[2] = 1'b0;
        @(negedge clk);
        check("single_start", div_start, 1);
        wait_rsp(2, cr, q, r, dz, er);
        check("single_latency", cr - ca, 26);
        check("single_quo", q, 142);
        check("single_rem", r, 6);
        check("single_dz", dz, 0);
        check("single_err", er, 0);

        // Divide by zero on requester 1.
        set_ops(1, W'(55), W'(0));
        @(posedge clk); #1 req[1] = 1'b1;
        next_ack(a, ca);
        check("dz_ack", a, 4'b0010);
        @(posedge clk); #1 req[1] = 1'b0;
        wait_rsp(1, cr, q, r, dz, er);
        check("dz_latency", cr - ca, 1);
        check("dz_quo", q, 8'hFF);
        check("dz_rem", r, 55);
        check("dz_flag", dz, 1);
        check("dz_err", er, 0);

        // Watchdog abort, then a late done in IDLE, then a normal division.
        lat_mode = 2;
        set_ops(0, W'(77777), W'(13));
        @(posedge clk); #1 req[0] = 1'b1;
        next_ack(a, ca);
        @(posedge clk); #1 req[0] = 1'b0;
        wait_rsp(0, cr, q, r, dz, er);
        check("wd_latency", cr - ca, 50);
        check("wd_err", er, 1);
        check("wd_quo", q, 0);
        check("wd_rem", r, 0);
        spur_cyc = cr + 2;
        lat_mode = 0;
        repeat (4) @(posedge clk);
        set_ops(3, W'(1000), W'(7));
        #1 req[3] = 1'b1;
        next_ack(a, ca);
        check("post_wd_ack", a, 4'b1000);
        @(posedge clk); #1 req[3] = 1'b0;
        wait_rsp(3, cr, q, r, dz, er);
        check("post_wd_latency", cr - ca, 26);
        check("post_wd_quo", q, 142);
        check("post_wd_rem", r, 6);
        check("post_wd_err", er, 0);

        // Reset mid-WAIT; held requests re-arbitrate from requester 0.
        set_ops(1, W'(5000), W'(3));
        @(posedge clk); #1 req[1] = 1'b1;
        next_ack(a, ca);
        repeat (10) @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_dividend", div_dividend, 0);
        check("midrst_start", div_start, 0);
        check("midrst_ack", ack, 0);
        set_ops(3, W'(999), W'(10));
        req[3] = 1'b1;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        next_ack(a, ca);
        check("rearb_first", a, 4'b0010);
        @(posedge clk); #1 req[1] = 1'b0;
        next_ack(a, ca);
        check("rearb_second", a, 4'b1000);
        @(posedge clk); #1 req[3] = 1'b0;
        wait_rsp(3, cr, q, r, dz, er);
        check("rearb_quo", q, 99);
        check("rearb_rem", r, 9);

        // Random traffic with random divider latency.
        lat_mode = 1;
        for (int t = 0; t < 2500; t++) begin
            @(negedge clk);
            acked = ack;
            @(posedge clk); #1;
            for (int k = 0; k < NREQ; k++) begin
                if (req[k] && acked[k]) begin
                    if ($urandom_range(0, 3) == 0) set_ops(k, W'($urandom), rnd_divisor());
                    else req[k] = 1'b0;
                end else if (!req[k] && $urandom_range(0, 5) == 0) begin
                    set_ops(k, W'($urandom), rnd_divisor());
                    req[k] = 1'b1;
                end
            end
        end
        req = '0;
        repeat (TO + 10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/div_scheduler.md
# div_scheduler

Shares one sequential divider (start/done handshake, WIDTH-bit dividend/divisor, 8-bit quotient, WIDTH-bit remainder) among NREQ requesters, e.g. the mixer's per-channel gain/normalisation paths. Arbitration is round-robin. The block captures the winner's operands, sequences the divider's start pulse, and waits for done. It returns the result to the winner with a one-cycle valid. Divide-by-zero is resolved locally without using the divider. A watchdog aborts a divider that never reports done.

## Interface
- WIDTH, 24, operand/remainder width; must match the divider instance
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 2*WIDTH, max cycles in WAIT before abort
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request level
- req_dividend  in  NREQ*WIDTH  packed operands; requester k at bits [k*WIDTH +: WIDTH]
- req_divisor  in  NREQ*WIDTH  packed, same layout
- ack  out  NREQ  one-hot, one-cycle grant/accept; operands sampled this cycle
- rsp_valid  out  NREQ  one-hot, one-cycle result strobe to the granted requester
- rsp_quo  out  8  quotient, valid with rsp_valid
- rsp_rem  out  WIDTH  remainder, valid with rsp_valid
- rsp_dz  out  1  divide-by-zero flag, valid with rsp_valid
- rsp_err  out  1  watchdog abort flag, valid with rsp_valid
- busy  out  1  high in every state except IDLE
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend, div_divisor  out  WIDTH each  held operands to the divider
- div_done  in  1  divider completion pulse
- div_quo  in  8 / div_rem  in  WIDTH  divider results, sampled when div_done is high

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE with req==0: no action. Pointer unchanged.
- IDLE with req!=0: combinationally select the first set req bit, scanning from ptr upward with wrap at NREQ-1 -> 0.
  - Assert ack[g] in that cycle.
  - At the clock edge, register g and the operands. Set ptr = (g+1) mod NREQ.
  - If the divisor is 0, go to RESP with rsp_quo=8'hFF, rsp_rem=dividend, rsp_dz=1.
  - Otherwise go to START.
- START: div_start=1 for exactly one cycle; div_dividend/div_divisor driven from the registered operands. Next state WAIT; clear the watchdog counter.
- WAIT: the counter increments each cycle.
  - div_done=1: capture div_quo/div_rem; rsp_dz=0, rsp_err=0; go to RESP.
  - Counter reaches TIMEOUT-1 without div_done: rsp_quo=0, rsp_rem=0, rsp_err=1; go to RESP.
  - If div_done and the timeout occur in the same cycle, div_done wins.
- RESP: rsp_valid[g]=1 for one cycle with the stored result. Next state IDLE.
- div_done is ignored in IDLE, START and RESP. A late done after an abort is dropped. The next div_start restarts the divider, because the divider gives start priority.
- Requester rules:
  - Hold req and operands stable until ack.
  - Operands may change freely after ack.
  - Keeping req high after ack is a new request, eligible at the next IDLE.
- rsp_quo, rsp_rem, rsp_dz and rsp_err hold their last values outside RESP. Only rsp_valid qualifies them.
- div_dividend and div_divisor hold their last values outside START/WAIT.

## Timing
- Reset values: ack=0, rsp_valid=0, rsp_quo=0, rsp_rem=0, rsp_dz=0, rsp_err=0, busy=0, div_start=0, div_dividend=0, div_divisor=0. State=IDLE, ptr=0, watchdog=0.
- Reset asserted mid-operation: return to IDLE immediately. The in-flight request is lost with no rsp_valid. The requester must re-request.
- Nonzero divisor, ack in cycle 0:
  - div_start in cycle 1.
  - Divider done expected in cycle 1+WIDTH.
  - rsp_valid in cycle 2+WIDTH (26 for WIDTH=24).
- Zero divisor: ack cycle 0, rsp_valid cycle 1.
- Earliest next ack is the cycle after RESP. Peak throughput is one division per WIDTH+3 cycles.
- Abort: rsp_valid in cycle 2+TIMEOUT after ack when done never arrives.
- ack is combinational from req and state. The response outputs and all div_* outputs are registered.

## Test plan
- Single request: req[2] with 1000/7 -> ack[2] at cycle 0, div_start at cycle 1, rsp_valid[2] at cycle 26 with quo=142, rem=6, dz=0, err=0.
- Divide by zero: req[1] with 55/0 -> ack[1], no div_start, rsp_valid[1] next cycle with quo=8'hFF, rem=55, dz=1.
- Fairness: all four req held high from reset -> grants in order 0,1,2,3,0,1 with ack spacing 27 cycles and no requester granted twice before the others.
- Pointer wrap: after a grant to 3, req={0,1} simultaneously -> 0 granted, then 1.
- Watchdog: divider model never pulses done, TIMEOUT=48 -> rsp_valid at cycle 50 with err=1, quo=0, rem=0. A late done during IDLE is ignored, and the next request completes normally.
- Reset mid-WAIT: nrst low at cycle 10 of a division -> all outputs 0 immediately, no rsp_valid. After release, the same request re-arbitrates starting from requester 0.
